// File: rtl/mux16_rr_arbiter_pkg.sv
// mux16_rr_arbiter_pkg: shared constants, FSM encoding and lane-slice helper
// for the 16-lane round-robin mux arbiter.
package mux16_rr_arbiter_pkg;
    localparam int DW   = 16;
    localparam int NREQ = 16;
    localparam int SELW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Base bit index of lane k inside the packed request data bus.
    function automatic int lane_base(input int k);
        return k * DW;
    endfunction
endpackage

// File: rtl/mux16_rr_arbiter_mux.sv
// mux_16x1: 16-bit wide, 16:1 select mux.
// Ports: a0..a15 data inputs, s 4-bit select, y selected word.
module mux_16x1
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [DW-1:0]   a0,
    input  logic [DW-1:0]   a1,
    input  logic [DW-1:0]   a2,
    input  logic [DW-1:0]   a3,
    input  logic [DW-1:0]   a4,
    input  logic [DW-1:0]   a5,
    input  logic [DW-1:0]   a6,
    input  logic [DW-1:0]   a7,
    input  logic [DW-1:0]   a8,
    input  logic [DW-1:0]   a9,
    input  logic [DW-1:0]   a10,
    input  logic [DW-1:0]   a11,
    input  logic [DW-1:0]   a12,
    input  logic [DW-1:0]   a13,
    input  logic [DW-1:0]   a14,
    input  logic [DW-1:0]   a15,
    input  logic [SELW-1:0] s,
    output logic [DW-1:0]   y
);
    always_comb begin
        case (s)
            4'd0:    y = a0;
            4'd1:    y = a1;
            4'd2:    y = a2;
            4'd3:    y = a3;
            4'd4:    y = a4;
            4'd5:    y = a5;
            4'd6:    y = a6;
            4'd7:    y = a7;
            4'd8:    y = a8;
            4'd9:    y = a9;
            4'd10:   y = a10;
            4'd11:   y = a11;
            4'd12:   y = a12;
            4'd13:   y = a13;
            4'd14:   y = a14;
            default: y = a15;
        endcase
    end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter sharing one 16:1 mux between 16 lanes,
// with a registered valid/ready output stage and a one-cycle grant pulse.
// Ports: clk, rst_n (async active-low); req_i/req_data_i requester side;
// gnt_o one-hot grant pulse; out_data_o/out_valid_o/out_ready_i/out_src_o
// output stage; busy_o activity flag.
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [DW-1:0]        out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [SELW-1:0]      out_src_o,
    output logic                 busy_o
);
    state_t          state, state_next;
    logic [SELW-1:0] last_q, start, off, sel;
    logic [NREQ-1:0] eligible;
    logic [DW-1:0]   mux_out;
    logic            any, load;

    // A lane granted last cycle still has req high with stale data; skip it.
    assign eligible = req_i & ~gnt_o;
    assign any      = |eligible;

    // Search starts one past the previous winner; the lowest eligible offset
    // from that point wins, so the 4-bit sum wraps naturally modulo 16.
    always_comb begin
        start = last_q + 4'd1;
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (eligible[SELW'(int'(start) + i)]) off = SELW'(i);
        sel = start + off;
    end

    mux_16x1 u_mux (
        .a0  (req_data_i[lane_base(0)  +: DW]),
        .a1  (req_data_i[lane_base(1)  +: DW]),
        .a2  (req_data_i[lane_base(2)  +: DW]),
        .a3  (req_data_i[lane_base(3)  +: DW]),
        .a4  (req_data_i[lane_base(4)  +: DW]),
        .a5  (req_data_i[lane_base(5)  +: DW]),
        .a6  (req_data_i[lane_base(6)  +: DW]),
        .a7  (req_data_i[lane_base(7)  +: DW]),
        .a8  (req_data_i[lane_base(8)  +: DW]),
        .a9  (req_data_i[lane_base(9)  +: DW]),
        .a10 (req_data_i[lane_base(10) +: DW]),
        .a11 (req_data_i[lane_base(11) +: DW]),
        .a12 (req_data_i[lane_base(12) +: DW]),
        .a13 (req_data_i[lane_base(13) +: DW]),
        .a14 (req_data_i[lane_base(14) +: DW]),
        .a15 (req_data_i[lane_base(15) +: DW]),
        .s   (sel),
        .y   (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    // A stalled HOLD stays put; otherwise a load keeps/enters HOLD.
    always_comb begin
        state_next = load ? HOLD : (state == HOLD && !out_ready_i) ? HOLD : IDLE;
    end

    always_comb begin
        out_valid_o = (state == HOLD);
        load        = any && (state == IDLE || out_ready_i);
        busy_o      = out_valid_o || (|req_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_o      <= '0;
            out_data_o <= '0;
            out_src_o  <= '0;
            last_q     <= 4'hF;
        end else begin
            gnt_o <= load ? (NREQ'(1) << sel) : '0;
            if (load) begin
                out_data_o <= mux_out;
                out_src_o  <= sel;
                last_q     <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and randomized checks of mux16_rr_arbiter
// against a behavioural round-robin model kept in the bench.
module tb_mux16_rr_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  req = '0;
    logic [255:0] data = '0;
    logic         ready = 1'b0;
    logic [15:0]  gnt;
    logic [15:0]  out_data;
    logic         out_valid;
    logic [3:0]   out_src;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_last = 15;
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;
    int          m_src = 0;
    logic [15:0] m_gnt = '0;

    mux16_rr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_data_i  (data),
        .gnt_o       (gnt),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_src_o   (out_src),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: first requesting, not-just-granted lane after the previous winner.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 15; m_valid = 0; m_data = 0; m_src = 0; m_gnt = 0;
        end else begin
            logic [15:0] elig;
            int w;
            bit found;
            elig = req & ~m_gnt;
            found = 0;
            w = 0;
            for (int k = 1; k <= 16; k++)
                if (!found && elig[(m_last + k) % 16]) begin
                    found = 1;
                    w = (m_last + k) % 16;
                end
            if (found && (!m_valid || ready)) begin
                m_data  = data[16*w +: 16];
                m_src   = w;
                m_last  = w;
                m_gnt   = 16'(1) << w;
                m_valid = 1;
            end else begin
                m_gnt = 0;
                if (m_valid && ready) m_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cmp_gnt", 32'(gnt), 32'(m_gnt));
        check("cmp_valid", 32'(out_valid), 32'(m_valid));
        check("cmp_data", 32'(out_data), 32'(m_data));
        check("cmp_src", 32'(out_src), 32'(m_src));
        check("cmp_busy", 32'(busy), 32'(m_valid | (|req)));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_src", 32'(out_src), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Single lane 0
        req = 16'h0001; data[15:0] = 16'hA5A5; ready = 1'b1;
        step();
        check("t1_gnt", 32'(gnt), 32'h0001);
        check("t1_data", 32'(out_data), 32'hA5A5);
        check("t1_src", 32'(out_src), 0);
        check("t1_valid", 32'(out_valid), 1);
        req = 16'h0000;
        step();
        check("t1_valid_drop", 32'(out_valid), 0);

        // All lanes, rotation 0..15,0
        pulse_reset();
        for (int k = 0; k < 16; k++) data[16*k +: 16] = 16'(k * 16'h0101);
        req = 16'hFFFF;
        for (int i = 0; i <= 16; i++) begin
            step();
            check("t2_src", 32'(out_src), 32'(i % 16));
            check("t2_gnt", 32'(gnt), 32'(16'(1) << (i % 16)));
            check("t2_data", 32'(out_data), 32'((i % 16) * 16'h0101));
        end
        req = 16'h0000;
        step();
        check("t2_valid_drop", 32'(out_valid), 0);

        // Stall with lanes 3 and 9
        req = 16'h0208; ready = 1'b0;
        step();
        check("t3_src", 32'(out_src), 3);
        check("t3_gnt", 32'(gnt), 32'h0008);
        req = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_src", 32'(out_src), 3);
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_gnt", 32'(gnt), 0);
        end
        ready = 1'b1;
        step();
        check("t3_src9", 32'(out_src), 9);
        check("t3_gnt9", 32'(gnt), 32'h0200);
        req = 16'h0000;
        step();

        // Wrap-around: drive last winner to 15, then lanes 0 and 15
        req = 16'h8000;
        step();
        req = 16'h0000;
        step();
        req = 16'h8001;
        step();
        check("t4_src0", 32'(out_src), 0);
        check("t4_gnt0", 32'(gnt), 32'h0001);
        req = 16'h8000;
        step();
        check("t4_src15", 32'(out_src), 15);
        check("t4_gnt15", 32'(gnt), 32'h8000);
        req = 16'h0000;
        step();

        // Lane 5 holds request one cycle after its grant
        req = 16'h0020;
        step();
        check("t5_src", 32'(out_src), 5);
        check("t5_gnt", 32'(gnt), 32'h0020);
        step();
        check("t5_no_regrant", 32'(gnt), 0);
        check("t5_valid_drop", 32'(out_valid), 0);
        req = 16'h0000;
        step();

        // Async reset mid-HOLD
        req = 16'h0410; ready = 1'b0;
        step();
        check("t6_src", 32'(out_src), 10);
        check("t6_valid", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_gnt", 32'(gnt), 0);
        check("t6_rst_data", 32'(out_data), 0);
        check("t6_rst_src", 32'(out_src), 0);
        step();
        rst_n = 1'b1; ready = 1'b1;
        step();
        check("t6_src4", 32'(out_src), 4);
        req = 16'h0400;
        step();
        check("t6_src10", 32'(out_src), 10);
        req = 16'h0000;
        step();

        // Randomized traffic obeying the requester rule
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 16; k++) begin
                if (req[k] && m_gnt[k]) begin
                    if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                    else data[16*k +: 16] = 16'($urandom);
                end else if (!req[k] && $urandom_range(0, 7) == 0) begin
                    req[k] = 1'b1;
                    data[16*k +: 16] = 16'($urandom);
                end
            end
            step();
        end
        req = 16'h0000; ready = 1'b1;
        repeat (3) step();
        check("end_idle", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Shares one 16-bit, 16:1 select mux between 16 requesters using round-robin arbitration.
- Each requester presents a 16-bit operand and a request; the arbiter picks one and drives the mux select. It registers the selected word into an output stage with a valid/ready handshake and returns a one-cycle grant to the winner.
- Sits between the operand sources and the ALU input stage.

Parameters:
- DW, 16, data width per lane and of the output word.
- NREQ, 16, number of requesters. Fixed at 16 because the select is 4 bits; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  16  request per lane; held high until that lane's gnt_o pulse.
- req_data_i  input  256  lane k data at [16k+15:16k]; stable while req_i[k] is high.
- gnt_o  output  16  one-hot, one-cycle pulse: winner's data has been captured.
- out_data_o  output  16  registered selected word.
- out_valid_o  output  1  out_data_o is valid.
- out_ready_i  input  1  consumer accepts the word when high with out_valid_o.
- out_src_o  output  4  lane index of the word in out_data_o.
- busy_o  output  1  high when out_valid_o is high or any req_i bit is high.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) sets:
  - out_valid_o=0, out_data_o=0, out_src_o=0, gnt_o=0.
  - last_q=4'hF, so lane 0 has highest priority after reset.
  - FSM to IDLE.
  - Any pending grant is lost; requesters keep req_i high and are re-arbitrated.
- Eligible mask: req_i & ~gnt_o. A lane granted in the previous cycle is excluded so stale data is never captured twice.
- Round-robin order: last_q+1, last_q+2, ..., last_q, all modulo 16. The winner is the first eligible lane in that order. The winner is computed combinationally and drives the mux select sel.
- The stage can load when out_valid_o==0, or when out_valid_o==1 and out_ready_i==1.
- FSM IDLE (out_valid_o=0):
  - If any lane is eligible, at the clock edge:
    - out_data_o <= mux output for sel
    - out_src_o <= sel
    - last_q <= sel
    - gnt_o <= onehot(sel)
    - out_valid_o <= 1
    - next state HOLD.
  - Otherwise gnt_o <= 0.
- FSM HOLD (out_valid_o=1):
  - out_ready_i=0: all registers hold; gnt_o <= 0.
  - out_ready_i=1 and a lane is eligible: back-to-back load as in IDLE. out_valid_o stays 1; state stays HOLD.
  - out_ready_i=1 and no lane is eligible: out_valid_o <= 0, gnt_o <= 0, next state IDLE. out_data_o and out_src_o hold their old values.
- Latency and throughput:
  - A request first eligible at edge t produces out_valid_o and gnt_o high after edge t+1.
  - Sustained throughput is one word per cycle when out_ready_i is held high and at least two lanes are requesting.
- Requester rule: after seeing gnt_o[k]=1, drop req_i[k] or present new data by the next edge.
- gnt_o is never asserted on a cycle where the stage was not loaded. At most one bit of gnt_o is high.
- out_valid_o, once high, never drops without out_ready_i=1 (no retraction). out_data_o is stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous events:
  - A new request arriving while the stage is stalled waits; it is not lost.
  - All 16 lanes requesting are served in rotation; no lane waits more than 15 grants.
- Wrap-around: with last_q=15, lane 0 is searched first.

Decomposition:
- Shared package holds:
  - constants DW=16, NREQ=16, SELW=4
  - FSM state encoding IDLE=1'b0, HOLD=1'b1
  - lane-slice helper (base index 16k).
- One sub-module: the team's existing 16-bit 16:1 mux (mux_16x1), instantiated with a0..a15 taken from the req_data_i slices and s=sel.
- The round-robin winner search stays inline: rotate the mask, priority-encode, add last_q+1 modulo 16.

Test Plan:
- Reset, then req_i=16'h0001 with lane0 data=16'hA5A5 and out_ready_i=1 -> after one edge: gnt_o=16'h0001, out_data_o=16'hA5A5, out_src_o=0, out_valid_o=1; the next cycle out_valid_o=0.
- req_i=16'hFFFF held, data[k]=k*16'h0101, out_ready_i=1 -> out_src_o sequence 0,1,...,15,0 on consecutive cycles with one-hot gnt_o matching.
- Lanes 3 and 9 requesting, out_ready_i=0 for 4 cycles -> out_src_o=3 held, out_valid_o=1, gnt_o pulses once. Then raise out_ready_i -> out_src_o=9 on the next edge.
- last_q=15 state, lanes 0 and 15 requesting -> lane 0 wins first, then lane 15.
- Single lane 5 holds req_i one cycle after its gnt_o with out_ready_i=1 -> no second capture of lane 5 that cycle; out_valid_o drops.
- Assert rst_n=0 mid-HOLD with out_valid_o=1 -> out_valid_o, gnt_o and out_data_o go to 0 immediately (asynchronously). After release, pending requests are re-arbitrated starting from lane 0.
